// File: rtl/fpgapu_sample_stream.sv
// fpgapu_sample_stream
//   Audio output stage between the APU and a host/DAC sink. Decimates the
//   per-clock APU sample, converts it from IN_WIDTH to OUT_WIDTH, buffers it
//   in a first-word-fall-through FIFO with a valid/ready handshake, and owns
//   the channel-mixer mask, which only changes on APU frame boundaries.
//
// Ports
//   i_clk            system clock
//   i_reset          synchronous reset, active-high
//   i_sample         APU mixed sample (IN_WIDTH, unsigned)
//   i_frame_pulse    APU frame strobe, one clock wide
//   i_mixer_req      requested mixer mask (CHANNELS)
//   o_mixer          applied mixer mask, to the APU
//   o_valid          FIFO head valid
//   i_ready          sink accepts the head this cycle
//   o_data           FIFO head sample (OUT_WIDTH)
//   o_level          current FIFO occupancy
//   o_overflow       sticky flag: a sample was dropped
//   i_clear_overflow clears o_overflow
module fpgapu_sample_stream #(
  parameter int IN_WIDTH   = 9,
  parameter int OUT_WIDTH  = 8,
  parameter int CHANNELS   = 4,
  parameter int DECIM      = 1,
  parameter int FIFO_DEPTH = 16,
  parameter int MODE       = 0
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic [IN_WIDTH-1:0]           i_sample,
  input  logic                          i_frame_pulse,
  input  logic [CHANNELS-1:0]           i_mixer_req,
  output logic [CHANNELS-1:0]           o_mixer,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [OUT_WIDTH-1:0]          o_data,
  output logic [$clog2(FIFO_DEPTH):0]   o_level,
  output logic                          o_overflow,
  input  logic                          i_clear_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(DECIM - 1);
  localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] LEVEL_ONE  = LW'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  // Width conversion selected at elaboration time by MODE.
  function automatic logic [OUT_WIDTH-1:0] convert_sample(input logic [IN_WIDTH-1:0] s);
    logic [IN_WIDTH-1:0]  shifted;
    logic [IN_WIDTH-1:0]  upper;
    logic [OUT_WIDTH-1:0] r;
    shifted = s >> (IN_WIDTH - OUT_WIDTH);
    upper   = s >> OUT_WIDTH;
    case (MODE)
      32'sd0:  r = s[OUT_WIDTH-1:0];
      32'sd1:  r = (upper != {IN_WIDTH{1'b0}}) ? {OUT_WIDTH{1'b1}} : s[OUT_WIDTH-1:0];
      32'sd2:  r = shifted[OUT_WIDTH-1:0];
      default: r = s[OUT_WIDTH-1:0];
    endcase
    return r;
  endfunction

  logic [CW-1:0]        cnt_r;
  logic [AW-1:0]        wr_ptr_r;
  logic [AW-1:0]        rd_ptr_r;
  logic [LW-1:0]        level_r;
  logic [OUT_WIDTH-1:0] head_r;
  logic                 valid_r;
  logic                 overflow_r;
  logic [CHANNELS-1:0]  mixer_r;
  logic [OUT_WIDTH-1:0] mem_r [FIFO_DEPTH];

  logic                 tick_s;
  logic                 pop_s;
  logic                 full_s;
  logic                 push_s;
  logic                 drop_s;
  logic [OUT_WIDTH-1:0] conv_s;
  logic [LW-1:0]        level_next_s;
  logic [LW-1:0]        remain_s;
  logic [AW-1:0]        rd_next_s;
  logic [OUT_WIDTH-1:0] head_next_s;

  assign tick_s = (cnt_r == CNT_LAST);
  assign pop_s  = valid_r & i_ready;
  assign full_s = (level_r == LEVEL_FULL);
  // A full FIFO still accepts the sample when the head leaves in the same cycle.
  assign push_s = tick_s & (~full_s | pop_s);
  assign drop_s = tick_s & full_s & ~pop_s;
  assign conv_s = convert_sample(i_sample);

  // Next occupancy, read pointer and registered head value.
  always_comb begin
    level_next_s = level_r;
    remain_s     = level_r;
    rd_next_s    = rd_ptr_r;
    head_next_s  = head_r;
    case ({push_s, pop_s})
      2'b10:   level_next_s = level_r + LEVEL_ONE;
      2'b01:   level_next_s = level_r - LEVEL_ONE;
      default: level_next_s = level_r;
    endcase
    if (pop_s) begin
      remain_s  = level_r - LEVEL_ONE;
      rd_next_s = rd_ptr_r + PTR_ONE;
    end else begin
      remain_s  = level_r;
      rd_next_s = rd_ptr_r;
    end
    // The head register is loaded straight from the converter when the
    // incoming sample becomes the head, otherwise from the stored entry.
    if (remain_s == {LW{1'b0}}) begin
      if (push_s) begin
        head_next_s = conv_s;
      end else begin
        head_next_s = head_r;
      end
    end else begin
      head_next_s = mem_r[rd_next_s];
    end
  end

  // Sample storage; entries need no reset since level gates their use.
  always_ff @(posedge i_clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= conv_s;
    end
  end

  // Decimation counter, FIFO control, overflow flag and mixer mask.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_r      <= {CW{1'b0}};
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      level_r    <= {LW{1'b0}};
      head_r     <= {OUT_WIDTH{1'b0}};
      valid_r    <= 1'b0;
      overflow_r <= 1'b0;
      mixer_r    <= {CHANNELS{1'b1}};
    end else begin
      if (tick_s) begin
        cnt_r <= {CW{1'b0}};
      end else begin
        cnt_r <= cnt_r + CNT_ONE;
      end
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      rd_ptr_r <= rd_next_s;
      level_r  <= level_next_s;
      head_r   <= head_next_s;
      valid_r  <= (level_next_s != {LW{1'b0}});
      // A drop wins over a simultaneous clear.
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (i_clear_overflow) begin
        overflow_r <= 1'b0;
      end
      if (i_frame_pulse) begin
        mixer_r <= i_mixer_req;
      end
    end
  end

  assign o_mixer    = mixer_r;
  assign o_valid    = valid_r;
  assign o_data     = head_r;
  assign o_level    = level_r;
  assign o_overflow = overflow_r;

endmodule

// File: tb/tb_fpgapu_sample_stream.sv
// Bench for fpgapu_sample_stream: four instances (MODE 0/1/2 at DECIM=1 and
// MODE 0 at DECIM=4) share one stimulus stream and are compared every cycle
// against a queue-based reference model, with literal expectations pinning
// the model on the directed scenarios.
module tb_fpgapu_sample_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] smp;
  logic       frame;
  logic [3:0] mreq;
  logic       rdy;
  logic       clr;

  logic [3:0] mix_s [4];
  logic       val_s [4];
  logic [7:0] dat_s [4];
  logic [4:0] lvl_s [4];
  logic       ovf_s [4];

  always #5 clk = ~clk;

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_dut
      fpgapu_sample_stream #(
        .IN_WIDTH(9), .OUT_WIDTH(8), .CHANNELS(4),
        .DECIM((g == 3) ? 4 : 1), .FIFO_DEPTH(16),
        .MODE((g == 1) ? 1 : ((g == 2) ? 2 : 0))
      ) u_dut (
        .i_clk(clk), .i_reset(rst), .i_sample(smp), .i_frame_pulse(frame),
        .i_mixer_req(mreq), .o_mixer(mix_s[g]), .o_valid(val_s[g]),
        .i_ready(rdy), .o_data(dat_s[g]), .o_level(lvl_s[g]),
        .o_overflow(ovf_s[g]), .i_clear_overflow(clr)
      );
    end
  endgenerate

  int checks = 0;
  int errors = 0;

  // reference model state, one set per instance
  int m_q   [4][16];
  int m_n   [4];
  int m_cnt [4];
  int m_ovf [4];
  int m_mix [4];
  int m_rst [4];

  function automatic int decim_of(int k);
    return (k == 3) ? 4 : 1;
  endfunction

  function automatic int conv(int k, int s);
    if (k == 1) return (s > 255) ? 255 : s;
    else if (k == 2) return s / 2;
    else return s % 256;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_update();
    for (int k = 0; k < 4; k++) begin
      if (rst) begin
        m_n[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0; m_mix[k] = 15; m_rst[k] = 1;
      end else begin
        bit tick, pop, drop;
        m_rst[k] = 0;
        tick = (m_cnt[k] == decim_of(k) - 1);
        m_cnt[k] = tick ? 0 : m_cnt[k] + 1;
        pop = (m_n[k] > 0) && rdy;
        if (frame) m_mix[k] = int'(mreq);
        if (pop) begin
          for (int j = 0; j < 15; j++) m_q[k][j] = m_q[k][j+1];
          m_n[k]--;
        end
        drop = 1'b0;
        if (tick) begin
          if (m_n[k] < 16) begin
            m_q[k][m_n[k]] = conv(k, int'(smp));
            m_n[k]++;
          end else begin
            drop = 1'b1;
          end
        end
        if (drop) m_ovf[k] = 1;
        else if (clr) m_ovf[k] = 0;
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("valid[%0d]", k), 32'(val_s[k]), 32'(m_n[k] > 0));
      chk($sformatf("level[%0d]", k), 32'(lvl_s[k]), m_n[k]);
      chk($sformatf("overflow[%0d]", k), 32'(ovf_s[k]), m_ovf[k]);
      chk($sformatf("mixer[%0d]", k), 32'(mix_s[k]), m_mix[k]);
      if (m_n[k] > 0) chk($sformatf("data[%0d]", k), 32'(dat_s[k]), m_q[k][0]);
      else if (m_rst[k] != 0) chk($sformatf("data_rst[%0d]", k), 32'(dat_s[k]), 0);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, advance the model, and
  // compare after the next rising edge has been applied.
  task automatic step(bit r, int s, bit f, int mr, bit rd, bit c);
    rst = r; smp = 9'(s); frame = f; mreq = 4'(mr); rdy = rd; clr = c;
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    int nv;
    rst = 1'b1; smp = 9'd0; frame = 1'b0; mreq = 4'd0; rdy = 1'b0; clr = 1'b0;
    @(negedge clk);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);

    // conversion of 0x1A5 in each mode, one cycle after the tick
    step(0, 9'h1A5, 0, 0, 1, 0);
    chk("mode0_data", 32'(dat_s[0]), 32'h0A5);
    chk("mode1_data", 32'(dat_s[1]), 32'h0FF);
    chk("mode2_data", 32'(dat_s[2]), 32'h0D2);
    chk("mode0_valid", 32'(val_s[0]), 32'd1);

    // ramp after reset: DECIM=4 instance emits 3,7,11, valid 1 cycle in 4
    step(1, 0, 0, 0, 1, 0);
    nv = 0;
    for (int i = 0; i < 12; i++) begin
      step(0, i, 0, 0, 1, 0);
      if (val_s[3]) nv++;
      chk("ramp_d1_data", 32'(dat_s[0]), i);
      if (i % 4 == 3) chk("ramp_d4_data", 32'(dat_s[3]), i);
    end
    chk("ramp_d4_valid_count", nv, 32'd3);

    // mixer mask only follows the request on a frame pulse
    step(0, 0, 0, 4'b0101, 1, 0);
    chk("mixer_no_pulse", 32'(mix_s[0]), 32'hF);
    step(0, 0, 1, 4'b0101, 1, 0);
    chk("mixer_pulse", 32'(mix_s[0]), 32'h5);
    step(0, 0, 0, 4'b1010, 1, 0);
    chk("mixer_hold", 32'(mix_s[0]), 32'h5);

    // fill with sink stalled for 20 clocks
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 9'h040 + i, 0, 0, 0, 0);
    chk("fill_level", 32'(lvl_s[0]), 32'd16);
    chk("fill_overflow", 32'(ovf_s[0]), 32'd1);
    chk("fill_head", 32'(dat_s[0]), 32'h40);

    // clear coincident with a drop keeps the flag
    step(0, 9'h0AA, 0, 0, 0, 1);
    chk("clr_with_drop", 32'(ovf_s[0]), 32'd1);
    // full FIFO with pop on a tick: push+pop, level holds, clear takes effect
    step(0, 9'h0AB, 0, 0, 1, 1);
    chk("full_pushpop_level", 32'(lvl_s[0]), 32'd16);
    chk("clr_no_drop", 32'(ovf_s[0]), 32'd0);
    chk("full_pushpop_head", 32'(dat_s[0]), 32'h41);
    step(0, 9'h0AC, 0, 0, 1, 0);
    chk("full_pushpop_ovf", 32'(ovf_s[0]), 32'd0);

    // reset mid-stream with 5 samples held
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 4'b0000, 0, 0);
    for (int i = 2; i <= 5; i++) step(0, i, 0, 0, 0, 0);
    chk("pre_reset_level", 32'(lvl_s[0]), 32'd5);
    step(1, 0, 0, 0, 0, 0);
    chk("reset_valid", 32'(val_s[0]), 32'd0);
    chk("reset_level", 32'(lvl_s[0]), 32'd0);
    chk("reset_mixer", 32'(mix_s[0]), 32'hF);
    chk("reset_overflow", 32'(ovf_s[0]), 32'd0);
    chk("reset_data", 32'(dat_s[0]), 32'd0);

    // randomized traffic with bursts of different sink readiness
    for (int i = 0; i < 3000; i++) begin
      int ph;
      bit rd;
      ph = (i / 150) % 3;
      if (ph == 0) rd = ($urandom_range(0, 3) == 0);
      else if (ph == 1) rd = ($urandom_range(0, 3) != 0);
      else rd = ($urandom_range(0, 1) == 0);
      step(($urandom_range(0, 299) == 0), int'($urandom_range(0, 511)),
           ($urandom_range(0, 15) == 0), int'($urandom_range(0, 15)), rd,
           ($urandom_range(0, 31) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
